// File: rtl/jk_bank_driver.sv
// -----------------------------------------------------------------------------
// jk_bank_driver
//
// Drives a bank of external JK master-slave flip-flops toward a requested next
// state, then reads the bank back and reports pass/fail.
//
// A target is accepted over a valid/ready handshake. J/K are derived from the
// JK excitation table using the bank's current q and driven for exactly one
// clock. After CHECK_LAT further edges, q_in is compared against the target and
// a done pulse (with err on mismatch) is produced.
//
// Parameters:
//   WIDTH      number of flip-flops in the driven bank
//   CHECK_LAT  edges after the drive edge before q_in is compared (1..15)
//   DC_VAL     value driven on excitation don't-care inputs (0 or 1)
//
// Ports:
//   clk        clock for this block and the driven bank
//   rst        synchronous active-high reset
//   tgt_valid  target request valid
//   tgt_ready  block can accept a target (IDLE and not in reset)
//   tgt_data   requested next q of the bank
//   q_in       current outputs of the driven bank
//   j, k       registered J/K drive to the bank
//   done       one-cycle pulse when a transaction completes
//   err        one-cycle pulse with done when the read-back mismatches
//   err_mask   per-bit mismatch of the last transaction, held until next done
//   err_cnt    failed-transaction count, saturating at 255
// -----------------------------------------------------------------------------
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int CHECK_LAT = 1,
  parameter int DC_VAL    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LP_DC_VEC = (DC_VAL != 0) ? '1 : '0;
  localparam logic [3:0]       LP_LAT    = CHECK_LAT[3:0];

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [3:0]       r_wait;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_err_mask;
  logic [7:0]       r_err_cnt;

  logic [WIDTH-1:0] w_j_nxt;
  logic [WIDTH-1:0] w_k_nxt;
  logic [WIDTH-1:0] w_mismatch;

  // Excitation table, bitwise: a 0 bit only needs J (K is don't-care),
  // a 1 bit only needs K (J is don't-care).
  assign w_j_nxt    = (~q_in & tgt_data) | ( q_in & LP_DC_VEC);
  assign w_k_nxt    = ( q_in & ~tgt_data) | (~q_in & LP_DC_VEC);
  assign w_mismatch = q_in ^ r_tgt;

  // Gated by rst so ready is low throughout reset, yet rises in the very
  // first cycle after rst drops without waiting for another edge.
  assign tgt_ready = (r_state == S_IDLE) && !rst;

  assign j        = r_j;
  assign k        = r_k;
  assign done     = r_done;
  assign err      = r_err;
  assign err_mask = r_err_mask;
  assign err_cnt  = r_err_cnt;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values and the block has no ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tgt      <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_wait     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_mask <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_j <= '0;
          r_k <= '0;
          if (tgt_valid) begin
            r_tgt   <= tgt_data;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          // J/K drop after a single cycle so a toggle code cannot toggle twice.
          r_j     <= '0;
          r_k     <= '0;
          r_wait  <= LP_LAT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == 4'd1) begin
            r_wait     <= '0;
            r_done     <= 1'b1;
            r_err      <= |w_mismatch;
            r_err_mask <= w_mismatch;
            if ((|w_mismatch) && (r_err_cnt != 8'hFF)) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        default: begin
          r_j     <= '0;
          r_k     <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_driver
//
// Two driver instances, each driving a behavioural JK bank:
//   u_a : WIDTH=4, CHECK_LAT=1, DC_VAL=0 (reset, set, mixed, identical, fault)
//   u_b : WIDTH=4, CHECK_LAT=3, DC_VAL=1 (toggle, reset during WAIT)
// Stimulus pushes the expected completion into a per-instance queue; a monitor
// per instance pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_jk_bank_driver;

  typedef struct packed {
    logic       err;
    logic [3:0] mask;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic bclr;

  logic       rst_a, valid_a, ready_a, done_a, err_a;
  logic [3:0] data_a, bank_a, j_a, k_a, mask_a, stuck_a;
  logic [7:0] cnt_a;

  logic       rst_b, valid_b, ready_b, done_b, err_b;
  logic [3:0] data_b, bank_b, j_b, k_b, mask_b;
  logic [7:0] cnt_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int n_vec = 0;
  int n_bad = 0;

  jk_bank_driver #(.WIDTH(4), .CHECK_LAT(1), .DC_VAL(0)) u_a (
    .clk(clk), .rst(rst_a), .tgt_valid(valid_a), .tgt_ready(ready_a),
    .tgt_data(data_a), .q_in(bank_a), .j(j_a), .k(k_a), .done(done_a),
    .err(err_a), .err_mask(mask_a), .err_cnt(cnt_a)
  );

  jk_bank_driver #(.WIDTH(4), .CHECK_LAT(3), .DC_VAL(1)) u_b (
    .clk(clk), .rst(rst_b), .tgt_valid(valid_b), .tgt_ready(ready_b),
    .tgt_data(data_b), .q_in(bank_b), .j(j_b), .k(k_b), .done(done_b),
    .err(err_b), .err_mask(mask_b), .err_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK characteristic: q+ = j & ~q | ~k & q
  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj,
                                         input logic [3:0] kk);
    return (jj & ~q) | (~kk & q);
  endfunction

  always @(posedge clk) begin
    if (bclr) begin
      bank_a <= '0;
      bank_b <= '0;
    end else begin
      bank_a <= jk_next(bank_a, j_a, k_a) & ~stuck_a;
      bank_b <= jk_next(bank_b, j_b, k_b);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", {31'd0, done_a}, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("a_err", {31'd0, err_a}, {31'd0, e_a.err});
        check("a_err_mask", {28'd0, mask_a}, {28'd0, e_a.mask});
        check("a_err_cnt", {24'd0, cnt_a}, {24'd0, e_a.cnt});
      end
    end
    if (err_a && !done_a) check("a_err_without_done", {31'd0, err_a}, 32'd0);
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", {31'd0, done_b}, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("b_err", {31'd0, err_b}, {31'd0, e_b.err});
        check("b_err_mask", {28'd0, mask_b}, {28'd0, e_b.mask});
        check("b_err_cnt", {24'd0, cnt_b}, {24'd0, e_b.cnt});
      end
    end
    if (err_b && !done_b) check("b_err_without_done", {31'd0, err_b}, 32'd0);
  end

  // Called on a negedge; returns on a negedge with ready high (or timeout).
  task automatic wait_ready_a();
    int n = 0;
    while (ready_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_wait", {31'd0, ready_a}, 32'd1);
  endtask

  task automatic wait_ready_b();
    int n = 0;
    while (ready_b !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_ready_wait", {31'd0, ready_b}, 32'd1);
  endtask

  // One transaction on u_a with hand-computed drive and completion values.
  task automatic send_a(input logic [3:0] tgt, input logic [3:0] ej, input logic [3:0] ek,
                        input logic ee, input logic [3:0] em, input logic [7:0] ec);
    wait_ready_a();
    data_a  = tgt;
    valid_a = 1'b1;
    q_a.push_back('{err: ee, mask: em, cnt: ec});
    @(negedge clk);
    check("a_drive_j", {28'd0, j_a}, {28'd0, ej});
    check("a_drive_k", {28'd0, k_a}, {28'd0, ek});
    check("a_busy_ready", {31'd0, ready_a}, 32'd0);
    valid_a = 1'b0;
    @(negedge clk);
    check("a_wait_jk", {24'd0, j_a, k_a}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    stuck_a = 4'b0000;
    bclr    = 1'b1;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    valid_a = 1'b1;
    data_a  = 4'b1010;
    valid_b = 1'b0;
    data_b  = 4'b0000;

    // Reset held two cycles with a request pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, ready_a}, 32'd0);
      check("rst_jk", {24'd0, j_a, k_a}, 32'd0);
      check("rst_cnt", {24'd0, cnt_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    bclr  = 1'b0;
    #1;

    // Set: 0000 -> 1010, accepted on the first edge after reset.
    send_a(4'b1010, 4'b1010, 4'b0000, 1'b0, 4'b0000, 8'd0);

    // Mixed: 1010 -> 0110 with valid held high; re-accepted only in IDLE,
    // which then runs an identical-target transaction (0110 -> 0110).
    wait_ready_a();
    data_a  = 4'b0110;
    valid_a = 1'b1;
    q_a.push_back('{err: 1'b0, mask: 4'b0000, cnt: 8'd0});
    @(negedge clk);
    check("mix_j", {28'd0, j_a}, 32'h4);
    check("mix_k", {28'd0, k_a}, 32'h8);
    @(negedge clk);
    check("mix_wait_ready", {31'd0, ready_a}, 32'd0);
    check("mix_wait_jk", {24'd0, j_a, k_a}, 32'd0);
    q_a.push_back('{err: 1'b0, mask: 4'b0000, cnt: 8'd0});
    @(negedge clk);
    check("mix_idle_ready", {31'd0, ready_a}, 32'd1);
    @(negedge clk);
    check("same_busy", {31'd0, ready_a}, 32'd0);
    check("same_jk", {24'd0, j_a, k_a}, 32'd0);
    valid_a = 1'b0;
    @(negedge clk);

    // Fault: bit0 stuck-at-0. First from 0110, then 299 more from 0000.
    stuck_a = 4'b0001;
    send_a(4'b0001, 4'b0001, 4'b0110, 1'b1, 4'b0001, 8'd1);
    for (int i = 1; i < 300; i++) begin
      send_a(4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001,
             (i + 1 > 255) ? 8'd255 : 8'(i + 1));
    end
    wait_ready_a();
    check("sat_cnt", {24'd0, cnt_a}, 32'd255);
    @(negedge clk);
    check("mask_hold", {28'd0, mask_a}, 32'h1);
    check("done_low", {31'd0, done_a}, 32'd0);

    // Toggle on u_b (DC_VAL=1): 0000 -> 1111 gives j=k=1111 for one cycle.
    wait_ready_b();
    data_b  = 4'b1111;
    valid_b = 1'b1;
    q_b.push_back('{err: 1'b0, mask: 4'b0000, cnt: 8'd0});
    @(negedge clk);
    check("tog_j", {28'd0, j_b}, 32'hF);
    check("tog_k", {28'd0, k_b}, 32'hF);
    valid_b = 1'b0;
    @(negedge clk);
    check("tog_jk_off1", {24'd0, j_b, k_b}, 32'd0);
    @(negedge clk);
    check("tog_jk_off2", {24'd0, j_b, k_b}, 32'd0);
    check("tog_bank", {28'd0, bank_b}, 32'hF);

    // Reset during the second WAIT cycle (CHECK_LAT=3): 1111 -> 0000 aborted.
    wait_ready_b();
    data_b  = 4'b0000;
    valid_b = 1'b1;
    @(negedge clk);
    check("rw_j", {28'd0, j_b}, 32'hF);
    check("rw_k", {28'd0, k_b}, 32'hF);
    valid_b = 1'b0;
    @(negedge clk);
    check("rw_wait1_jk", {24'd0, j_b, k_b}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("rw_rst_jk", {24'd0, j_b, k_b}, 32'd0);
    check("rw_rst_ready", {31'd0, ready_b}, 32'd0);
    check("rw_rst_cnt", {24'd0, cnt_b}, 32'd0);
    check("rw_rst_done", {31'd0, done_b}, 32'd0);
    rst_b = 1'b0;
    #1;
    check("rw_ready_after", {31'd0, ready_b}, 32'd1);
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("rw_ready_idle", {31'd0, ready_b}, 32'd1);
    check("rw_cnt_final", {24'd0, cnt_b}, 32'd0);
    check("rw_jk_final", {24'd0, j_b, k_b}, 32'd0);

    check("a_pending", q_a.size(), 32'd0);
    check("b_pending", q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Transmit-side controller for a bank of external JK master-slave flip-flops. It accepts a requested next state for the bank over a valid/ready handshake and drives `j`/`k` for exactly one clock, using the JK excitation table and the bank's current `q`. It then reads back `q` and reports pass or fail. It is the stimulus and checking end of the JK interface, used in self-checking flop-bank harnesses and register-style control built from JK cells.

## Interface
Parameters:
- `WIDTH`, default 4: number of flip-flops in the driven bank.
- `CHECK_LAT`, default 1: clock edges after the drive edge before `q_in` is compared. Legal values are 1..15.
- `DC_VAL`, default 0: value driven on excitation don't-care inputs. Legal values are 0 or 1.

Ports:
- `clk`  in  1  single clock for the block and the driven bank.
- `rst`  in  1  reset, synchronous, active-high.
- `tgt_valid`  in  1  target request valid.
- `tgt_ready`  out  1  block can accept a target.
- `tgt_data`  in  WIDTH  requested next `q` of the bank.
- `q_in`  in  WIDTH  current outputs of the driven bank.
- `j`  out  WIDTH  J drive to the bank, registered.
- `k`  out  WIDTH  K drive to the bank, registered.
- `done`  out  1  one-cycle pulse when a transaction completes.
- `err`  out  1  one-cycle pulse with `done` when the read-back mismatches.
- `err_mask`  out  WIDTH  per-bit mismatch of the last transaction (`q_in ^ target`). Holds until the next `done`.
- `err_cnt`  out  8  count of failed transactions, saturating at 255.

## Operation
- **State machine:** IDLE -> DRIVE -> WAIT -> IDLE.
- **IDLE:**
  - `tgt_ready`=1 and `j`=`k`=0, so the bank holds its state.
  - When `tgt_valid` & `tgt_ready` at an edge: latch the target, compute `j`/`k` from `q_in` sampled at that edge, and go to DRIVE.
- **Excitation per bit (current -> target):**
  - 0->0: j=0, k=DC_VAL
  - 0->1: j=1, k=DC_VAL
  - 1->0: j=DC_VAL, k=1
  - 1->1: j=DC_VAL, k=0
- **DRIVE:**
  - Lasts one cycle and holds `j`/`k` while the bank samples them.
  - At the next edge: `j`=`k`=0, load the wait counter with CHECK_LAT, go to WAIT.
  - `j`/`k` are never held non-zero for more than one cycle, so toggle (j=k=1) cannot double-toggle.
- **WAIT:**
  - The counter decrements each edge.
  - On the edge where it reaches zero:
    - compare `q_in` to the target;
    - register `done`=1, `err`=|mismatch and `err_mask`=mismatch;
    - increment `err_cnt` if mismatch, unless it is already 255;
    - return to IDLE.
- **Handshake while busy:** `tgt_ready`=0 in DRIVE and WAIT. `tgt_valid` and `tgt_data` are ignored there; a request held high is accepted on the first IDLE edge.
- **Identical target:** a target equal to the current `q` is a legal transaction. It produces the hold/set-reset codes above and checks normally.

## Timing
- Accept edge T0: `j`/`k` valid from T0 to T1.
- Bank updates at T1; `j`=`k`=0 after T1.
- Compare at edge T1+CHECK_LAT; `done`/`err` high for exactly the following cycle.
- Next accept possible at T1+CHECK_LAT+1. Minimum period is CHECK_LAT+2 cycles (3 at default).
- **Reset values** (while `rst`=1 and after its last edge):
  - state IDLE, `j`=`k`=0
  - `tgt_ready`=0 while `rst` is high, 1 from the first cycle after
  - `done`=`err`=0, `err_mask`=0, `err_cnt`=0
- **Reset mid-transaction:** abort at that edge, with no `done` or `err` pulse and the latched target discarded.
- **Simultaneous events:** `rst` wins over accept and compare.

## Test plan
- **Reset:** hold `rst` high 2 cycles with `tgt_valid`=1.
  - During reset: `tgt_ready`=0, `j`=`k`=0, `err_cnt`=0.
  - Accept occurs on the first edge after reset.
- **Set, WIDTH=4, DC_VAL=0, CHECK_LAT=1:** bank at 0000, target 1010.
  - `j`=1010, `k`=0000 for one cycle.
  - `done` one cycle later, `err`=0, bank reads 1010.
- **Mixed transition:** from 1010, target 0110.
  - `j`=0100, `k`=1000.
  - Pass; `tgt_valid` held high during the transaction is not re-accepted until IDLE.
- **Fault:** model bit0 stuck-at-0, target 0001.
  - `err`=1, `err_mask`=0001, `err_cnt`=1.
  - Repeat 300 times; `err_cnt` stops at 255.
- **Toggle, DC_VAL=1:** bank 0000, target 1111.
  - `j`=`k`=1111 for exactly one cycle.
  - Bank reads 1111 (no double toggle), `err`=0.
- **Reset in WAIT:** assert `rst` (CHECK_LAT=3) at the second WAIT cycle.
  - No `done` pulse; `j`=`k`=0; `err_cnt` unchanged at 0.
  - `tgt_ready`=1 the cycle after `rst` drops.
